// File: rtl/pool_pad_stream_pkg.sv
// Shared SPPF definitions used by the pooling pipeline stages.
//   POOL_K / SPPF_PAD    : pool window size and the "same"-size border it needs
//   pool_state_e         : plane-buffer FSM states
//   sppf_min_value()     : most negative two's complement value for a pixel width
//   sppf_padded_size()   : element count of a padded plane
//   sppf_cnt_width()     : counter width for n values, never below 1
package pool_pad_stream_pkg;

  localparam int unsigned POOL_K   = 5;
  localparam int unsigned SPPF_PAD = (POOL_K - 1) / 2;

  typedef enum logic {
    StFill,
    StHold
  } pool_state_e;

  // Caller truncates to its own width; valid for widths up to 64.
  function automatic logic [63:0] sppf_min_value(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic int unsigned sppf_padded_size(input int unsigned h, input int unsigned w,
                                                   input int unsigned pad);
    return (h + 2 * pad) * (w + 2 * pad);
  endfunction

  function automatic int unsigned sppf_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_pad_stream.sv
// Input stage of the SPPF max-pool chain. Buffers one HxW plane per channel from a pixel-serial
// valid/ready stream and presents it as a flat padded plane with a PAD_VALUE border.
//   clk, reset        : clock, asynchronous active-high reset
//   in_data/valid/ready : raster-order pixel stream, channel-major across planes
//   out_plane         : padded plane, element k = r*(W+2*PAD)+c at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready   : plane handshake; plane stays stable until consumed
//   out_ch, out_last  : channel index of the plane and flag for channel D-1
module pool_pad_stream
  import pool_pad_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 6,
  parameter int unsigned W          = 6,
  parameter int unsigned PAD        = SPPF_PAD,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = DATA_WIDTH'(sppf_min_value(DATA_WIDTH))
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [DATA_WIDTH-1:0]                                  in_data,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  output logic [0:sppf_padded_size(H, W, PAD)*DATA_WIDTH-1]      out_plane,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [sppf_cnt_width(D)-1:0]                           out_ch,
  output logic                                                   out_last
);

  localparam int unsigned RowW = sppf_cnt_width(H);
  localparam int unsigned ColW = sppf_cnt_width(W);
  localparam int unsigned ChW  = sppf_cnt_width(D);
  localparam int          PadI = int'(PAD);
  localparam int          HI   = int'(H);
  localparam int          WI   = int'(W);
  localparam int          PW   = WI + 2 * PadI;
  localparam int          PH   = HI + 2 * PadI;

  pool_state_e           r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_last;
  logic [RowW-1:0]       r_row;
  logic [ColW-1:0]       r_col;
  logic [ChW-1:0]        r_ch;
  logic [DATA_WIDTH-1:0] r_buf [H][W];
  logic [ChW-1:0]        w_ch_next;

  assign w_ch_next = (r_ch == ChW'(D - 1)) ? '0 : r_ch + ChW'(1);

  // Handshake outputs are registered copies of the state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StFill;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_ch        <= '0;
      r_last      <= (D == 1);
      for (int r = 0; r < HI; r++) begin
        for (int c = 0; c < WI; c++) begin
          r_buf[r][c] <= '0;
        end
      end
    end else begin
      unique case (r_state)
        StFill: begin
          if (in_valid) begin
            r_buf[r_row][r_col] <= in_data;
            if (r_col == ColW'(W - 1)) begin
              r_col <= '0;
              if (r_row == RowW'(H - 1)) begin
                r_row       <= '0;
                r_state     <= StHold;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
              end else begin
                r_row <= r_row + RowW'(1);
              end
            end else begin
              r_col <= r_col + ColW'(1);
            end
          end
        end
        StHold: begin
          // Buffer is frozen here; in_valid is ignored until the plane is consumed.
          if (out_ready) begin
            r_state     <= StFill;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ch        <= w_ch_next;
            r_last      <= (w_ch_next == ChW'(D - 1));
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ch    = r_ch;
  assign out_last  = r_last;

  // Pure wiring: interior elements map to the buffer, the border is the constant pad value.
  for (genvar r = 0; r < PH; r++) begin : g_row
    for (genvar c = 0; c < PW; c++) begin : g_col
      if (r >= PadI && r < HI + PadI && c >= PadI && c < WI + PadI) begin : g_in
        assign out_plane[(r*PW+c)*DATA_WIDTH +: DATA_WIDTH] = r_buf[r-PadI][c-PadI];
      end else begin : g_pad
        assign out_plane[(r*PW+c)*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

endmodule

// File: tb/tb_pool_pad_stream.sv
module tb_pool_pad_stream;

  localparam int DW = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0][DW-1:0] in_data;
  logic [2:0]         in_valid;
  logic [2:0]         in_ready;
  logic [2:0]         out_valid;
  logic [2:0]         out_ready;
  logic [2:0]         out_last;
  logic               out_ch_a;
  logic [1:0]         out_ch_b;
  logic               out_ch_c;
  logic [0:1599]      plane_a;
  logic [0:1599]      plane_b;
  logic [0:399]       plane_c;

  int                 n_cmp = 0;
  int                 n_bad = 0;
  logic [DW-1:0]      sent[$];

  always #5 clk = ~clk;

  // Instance 0: defaults (6x6, PAD=2, D=1)
  pool_pad_stream #(.D(1)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_plane(plane_a), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_ch(out_ch_a), .out_last(out_last[0])
  );

  // Instance 1: three-channel frame
  pool_pad_stream #(.D(3)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_plane(plane_b), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_ch(out_ch_b), .out_last(out_last[1])
  );

  // Instance 2: 5x5 with no border
  pool_pad_stream #(.H(5), .W(5), .PAD(0)) u_dut_c (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_plane(plane_c), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_ch(out_ch_c), .out_last(out_last[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int s, input int k);
    case (s)
      0:       return plane_a[k*DW +: DW];
      1:       return plane_b[k*DW +: DW];
      default: return plane_c[k*DW +: DW];
    endcase
  endfunction

  // Offers one pixel and waits (bounded) until it is accepted.
  task automatic feed(input int s, input logic [DW-1:0] px);
    bit ok = 1'b0;
    bit rdy;
    in_data[s]  = px;
    in_valid[s] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rdy = in_ready[s];
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid[s] = 1'b0;
    if (ok) sent.push_back(px);
    else check_eq("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume(input int s);
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[s] = 1'b0;
  endtask

  task automatic check_interior(input int s, input int h, input int w, input int pad,
                                input string tag);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        check_eq($sformatf("%s[%0d,%0d]", tag, r, c),
                 32'(elem(s, (r + pad) * (w + 2 * pad) + c + pad)), 32'(sent[r*w+c]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_out_ch", 32'(out_ch_a), 32'd0);
    check_eq("rst_out_last_d1", 32'(out_last[0]), 32'd1);
    check_eq("rst_border", 32'(elem(0, 0)), 32'h8000);
    check_eq("rst_interior", 32'(elem(0, 22)), 32'h0);
    check_eq("rst_out_last_d3", 32'(out_last[1]), 32'd0);
    check_eq("rst_out_ch_d3", 32'(out_ch_b), 32'd0);
    check_eq("rst_nopad_elem0", 32'(elem(2, 0)), 32'h0);

    // Back-to-back 1..36 with out_ready high throughout
    out_ready[0] = 1'b1;
    sent.delete();
    for (int i = 1; i <= 36; i++) feed(0, DW'(i));
    check_eq("b2b_out_valid", 32'(out_valid[0]), 32'd1);
    check_eq("b2b_in_ready", 32'(in_ready[0]), 32'd0);
    check_eq("b2b_e22", 32'(elem(0, 22)), 32'd1);
    check_eq("b2b_e77", 32'(elem(0, 77)), 32'd36);
    check_eq("b2b_e0", 32'(elem(0, 0)), 32'h8000);
    check_eq("b2b_e9", 32'(elem(0, 9)), 32'h8000);
    check_eq("b2b_e90", 32'(elem(0, 90)), 32'h8000);
    check_eq("b2b_e99", 32'(elem(0, 99)), 32'h8000);
    check_eq("b2b_out_last", 32'(out_last[0]), 32'd1);
    check_eq("b2b_out_ch", 32'(out_ch_a), 32'd0);
    check_interior(0, 6, 6, 2, "b2b");
    @(posedge clk);
    #1;
    check_eq("b2b_valid_drop", 32'(out_valid[0]), 32'd0);
    check_eq("b2b_ready_back", 32'(in_ready[0]), 32'd1);
    out_ready[0] = 1'b0;

    // Backpressure: pending plane held while in_valid is asserted
    sent.delete();
    for (int i = 1; i <= 36; i++) feed(0, DW'(100 + i));
    check_eq("bp_out_valid", 32'(out_valid[0]), 32'd1);
    in_data[0]  = 16'h7FFF;
    in_valid[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_in_ready_%0d", t), 32'(in_ready[0]), 32'd0);
      check_eq($sformatf("bp_out_valid_%0d", t), 32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    check_interior(0, 6, 6, 2, "bp_hold");
    consume(0);
    check_eq("bp_released", 32'(out_valid[0]), 32'd0);
    sent.delete();
    feed(0, 16'h7FFF);
    for (int i = 1; i < 36; i++) feed(0, DW'(200 + i));
    check_eq("bp_first_at_00", 32'(elem(0, 22)), 32'h7FFF);
    check_interior(0, 6, 6, 2, "bp_next");
    consume(0);

    // Random idle gaps, negative pixels
    sent.delete();
    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk);
        #1;
      end
      feed(0, DW'(16'hFFF0 - 16'(i * 7)));
    end
    check_eq("gap_out_valid", 32'(out_valid[0]), 32'd1);
    check_eq("gap_e22_neg", 32'(elem(0, 22)), 32'hFFF0);
    check_interior(0, 6, 6, 2, "gap");
    consume(0);

    // Reset mid-fill discards the partial plane
    for (int i = 0; i < 20; i++) feed(0, DW'(300 + i));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    sent.delete();
    for (int i = 0; i < 36; i++) begin
      feed(0, DW'(500 + i));
      if (i < 35) check_eq($sformatf("mid_rst_early_%0d", i), 32'(out_valid[0]), 32'd0);
    end
    check_eq("mid_rst_valid", 32'(out_valid[0]), 32'd1);
    check_eq("mid_rst_out_ch", 32'(out_ch_a), 32'd0);
    check_interior(0, 6, 6, 2, "mid_rst");
    consume(0);

    // Three-channel frame: ch 0,1,2,0
    for (int p = 0; p < 4; p++) begin
      sent.delete();
      for (int i = 0; i < 36; i++) feed(1, DW'(p * 64 + i + 1));
      check_eq($sformatf("d3_valid_%0d", p), 32'(out_valid[1]), 32'd1);
      check_eq($sformatf("d3_ch_%0d", p), 32'(out_ch_b), 32'(p % 3));
      check_eq($sformatf("d3_last_%0d", p), 32'(out_last[1]), (p == 2) ? 32'd1 : 32'd0);
      check_interior(1, 6, 6, 2, $sformatf("d3_p%0d", p));
      consume(1);
      check_eq($sformatf("d3_drop_%0d", p), 32'(out_valid[1]), 32'd0);
    end

    // No border: plane equals the input sequence
    sent.delete();
    for (int i = 0; i < 25; i++) feed(2, DW'(16'hF000 + 16'(i * 3)));
    check_eq("nopad_valid", 32'(out_valid[2]), 32'd1);
    check_eq("nopad_e0", 32'(elem(2, 0)), 32'hF000);
    check_eq("nopad_e24", 32'(elem(2, 24)), 32'hF048);
    check_interior(2, 5, 5, 0, "nopad");
    consume(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_pad_stream.md
# pool_pad_stream

Streaming input stage for the SPPF 5×5 max-pool chain. It collects one H×W feature-map plane per channel from a pixel-serial valid/ready stream. It then presents that plane as a flat (H+2·PAD)×(W+2·PAD) vector, surrounded by a border of PAD_VALUE, so the stride-1 5×5 max-pool stage downstream returns an H×W ("same"-size) result. Channels are handled one plane at a time, with a channel index alongside each plane.

## Interface
- DATA_WIDTH, 16: pixel width, signed two's complement fixed point
- D, 1: channels per frame
- H, 6: unpadded plane height
- W, 6: unpadded plane width
- PAD, 2: border width on each side; (5−1)/2 for the 5×5 pool
- PAD_VALUE, 16'h8000: border pixel value, the most negative DATA_WIDTH value
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_data  in  DATA_WIDTH  pixel, raster order (row-major), channel-major across planes
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a pixel
- out_plane  out  (H+2·PAD)·(W+2·PAD)·DATA_WIDTH  padded plane, declared [0:N−1]; element k occupies bits [k·DATA_WIDTH +: DATA_WIDTH], k = r·(W+2·PAD)+c
- out_valid  out  1  out_plane holds a complete padded plane
- out_ready  in  1  downstream consumes the plane
- out_ch  out  $clog2(D) (min 1)  channel index of the plane on out_plane
- out_last  out  1  out_plane is channel D−1 of the frame

## Operation
- FSM states:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- FILL:
  - Each input transfer writes in_data to buf[row][col], then advances col.
  - col wraps at W−1 to 0 and increments row.
  - The transfer at row=H−1, col=W−1 moves the FSM to HOLD and clears row and col.
- HOLD:
  - out_plane element (r,c) = buf[r−PAD][c−PAD] when PAD≤r<H+PAD and PAD≤c<W+PAD; otherwise PAD_VALUE.
  - out_plane, out_ch and out_last stay stable until the output transfer.
  - On the output transfer: FSM returns to FILL; ch increments, and wraps from D−1 to 0.
- out_last = (ch == D−1).
- No arithmetic is performed. Pixels pass through bit-exact.
- PAD=0 is legal: out_plane equals the buffered plane.
- in_valid while in_ready=0 is ignored. No pixel is consumed and no state changes.

## Timing
- Reset values:
  - FSM=FILL, in_ready=1, out_valid=0.
  - row=col=ch=0, out_ch=0.
  - out_last=1 if D==1, else 0.
  - buf is cleared to 0, so out_plane shows PAD_VALUE border and 0 interior.
- Throughput: one pixel per cycle in FILL.
- Latency: out_valid rises on the first clk edge after the final (H·W-th) pixel transfer.
- If out_ready is held high, one HOLD cycle occurs per plane. A plane therefore costs H·W+1 cycles.
- The bubble is intentional: single buffer, no double-buffering.
- Reset mid-FILL or mid-HOLD discards the partial or pending plane. The next accepted pixel is treated as (0,0) of channel 0.
- out_ready asserted outside HOLD has no effect.

## Structure
- Shared SPPF package holds:
  - POOL_K=5 and SPPF_PAD=(POOL_K−1)/2.
  - The most-negative-value constant/function per DATA_WIDTH.
  - The padded-size helper function (H+2·PAD)·(W+2·PAD).
  - Both pool stages share these items.
- Single module; no sub-module.
- Padding assembly is a generate loop over (r,c) selecting buf or PAD_VALUE.

## Test plan
- Defaults (H=W=6, PAD=2, D=1):
  - Stimulus: feed pixels 1..36 back-to-back, out_ready=1.
  - out_valid rises one cycle after pixel 36 and stays high 1 cycle.
  - Element 22 (r=2,c=2) = 1; element 77 (r=7,c=7) = 36.
  - Elements 0, 9, 90 and 99 = 16'h8000.
  - out_last=1.
- Backpressure, D=1:
  - Stimulus: hold out_ready=0 for 10 cycles in HOLD, with in_valid=1 and pixel 16'h7FFF.
  - in_ready=0 throughout; the plane is unchanged and no pixel is consumed.
  - After out_ready=1, the next pixel lands at (0,0).
- Random in_valid gaps: 30% idle.
  - out_plane interior matches the sent sequence, in order.
  - Negative pixels (e.g. 16'hFFF0) pass through bit-exact.
- D=3 frame:
  - out_ch sequence is 0,1,2,0.
  - out_last=1 only with ch 2.
  - Each plane's interior matches its 36 pixels.
- Reset mid-operation:
  - Stimulus: assert reset after 20 pixels, then send 36 new pixels.
  - out_valid stays 0 until all 36 new pixels arrive; the interior holds only the new data, and out_ch=0.
- PAD=0, H=W=5:
  - out_plane width = 25·16 bits and equals the input sequence.
  - No PAD_VALUE elements appear.
